// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags.
// Decimal ADD/SUB resolved one BCD nibble per cycle.
module alu_seq #(
   parameter int W      = 8,
   parameter bit DEC_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] ai,
   input  logic [W-1:0] bi,
   input  logic         ci,
   input  logic [2:0]   op,
   input  logic         dec,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         n_o,
   output logic         v_o,
   output logic         z_o,
   output logic         c_o
);

   localparam int ND = W / 4;
   localparam int KW = $clog2(ND + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DEC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   state;
   logic [W-1:0] a_r, b_r, acc;
   logic         sub_r, cy_r, vd_r;
   logic [KW-1:0] k;

   logic         take, dgo, last;
   logic [W-1:0] lo, bsel, res;
   logic [W:0]   sum;
   logic         bn, bv, bz, bc;

   logic [3:0]   an, bn4, dig;
   logic [4:0]   s;
   logic [5:0]   d;
   logic         cn;
   logic [W-1:0] nxt;

   assign in_ready  = (state == IDLE) ||
                      (state == DONE && out_ready);
   assign out_valid = (state == DONE);
   assign take = in_valid && in_ready && !flush;
   assign dgo  = DEC_EN && dec && (op[2:1] == 2'b11);
   assign last = (k == KW'(ND - 1));

   always_comb begin
      lo   = ai | bi;
      bsel = (op == 3'd7) ? ~bi : bi;
      sum  = {1'b0, ai} + {1'b0, bsel} +
             {{W{1'b0}}, ci};
      res  = '0;
      bc   = 1'b0;
      unique case (1'b1)
         op == 3'd0,
         op == 3'd1: res = ai & bi;
         op == 3'd2: res = lo;
         op == 3'd3: res = ai ^ bi;
         op == 3'd4: begin
            res = {ci, lo[W-1:1]};
            bc  = lo[0];
         end
         op == 3'd5: begin
            res = {lo[W-2:0], ci};
            bc  = lo[W-1];
         end
         default: begin
            res = sum[W-1:0];
            bc  = sum[W];
         end
      endcase
      bn = (op == 3'd0) ? bi[W-1] : res[W-1];
      bv = (op == 3'd0) ? bi[W-2] :
           (ai[W-1] ^ res[W-1]) &
           (bsel[W-1] ^ res[W-1]);
      bz = (res == '0);
   end

   // one BCD digit of the latched operands, selected by k
   always_comb begin
      an  = 4'(a_r >> {k, 2'b00});
      bn4 = 4'(b_r >> {k, 2'b00});
      s   = {1'b0, an} + {1'b0, bn4} + {4'b0, cy_r};
      d   = {2'b0, an} - {2'b0, bn4} - {5'b0, ~cy_r};
      dig = s[3:0];
      cn  = 1'b0;
      if (sub_r) begin
         if (d[5]) begin
            dig = 4'(d + 6'd10);
            cn  = 1'b0;
         end else begin
            dig = d[3:0];
            cn  = 1'b1;
         end
      end else if (s > 5'd9) begin
         dig = 4'(s + 5'd6);
         cn  = 1'b1;
      end
      nxt = (acc & ~(W'(4'hF) << {k, 2'b00})) |
            (W'(dig) << {k, 2'b00});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out   <= '0;
         n_o   <= 1'b0;
         v_o   <= 1'b0;
         z_o   <= 1'b0;
         c_o   <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         sub_r <= 1'b0;
         cy_r  <= 1'b0;
         vd_r  <= 1'b0;
         k     <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else if (take) begin
         if (dgo) begin
            state <= DEC;
            a_r   <= ai;
            b_r   <= bi;
            sub_r <= op[0];
            cy_r  <= ci;
            vd_r  <= bv;
            acc   <= '0;
            k     <= '0;
         end else begin
            state <= DONE;
            out   <= res;
            n_o   <= bn;
            v_o   <= bv;
            z_o   <= bz;
            c_o   <= bc;
         end
      end else if (state == DEC) begin
         acc  <= nxt;
         cy_r <= cn;
         k    <= k + KW'(1);
         if (last) begin
            state <= DONE;
            out   <= nxt;
            c_o   <= cn;
            z_o   <= (nxt == '0);
            n_o   <= nxt[W-1];
            v_o   <= vd_r;
         end
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, random ops vs a digit-level
// model, and hand sequences for hold/flush/reset.
module tb_alu_seq;

   typedef struct {
      int o;
      bit n, v, z, c;
      int edges;
   } res_t;

   typedef struct {
      int op;
      bit dec;
      int a, b;
      bit ci;
      int eo;
      bit en, ev, ez, ec;
      int edges;
   } vec_t;

   logic       clk = 0;
   logic       rst_n = 0;
   logic       in_valid = 0, in_ready;
   logic [7:0] ai = 0, bi = 0, out;
   logic       ci = 0, dec = 0, flush = 0;
   logic [2:0] op = 0;
   logic       out_valid, out_ready = 1;
   logic       n_o, v_o, z_o, c_o;

   logic        w_valid = 0, w_ready;
   logic [15:0] w_a = 0, w_b = 0, w_out;
   logic        w_ci = 0, w_dec = 0;
   logic [2:0]  w_op = 0;
   logic        w_ovalid;
   logic        w_n, w_v, w_z, w_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_seq #(.W(8), .DEC_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .ai(ai), .bi(bi), .ci(ci), .op(op),
      .dec(dec), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .n_o(n_o), .v_o(v_o),
      .z_o(z_o), .c_o(c_o)
   );

   alu_seq #(.W(16), .DEC_EN(1'b1)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_valid), .in_ready(w_ready),
      .ai(w_a), .bi(w_b), .ci(w_ci), .op(w_op),
      .dec(w_dec), .flush(1'b0),
      .out_valid(w_ovalid), .out_ready(1'b1),
      .out(w_out), .n_o(w_n), .v_o(w_v),
      .z_o(w_z), .c_o(w_c)
   );

   task automatic chk(string nm, logic [31:0] got,
                      logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h want %0h",
                  nm, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, decimal done digit by
   // digit as a person would on paper.
   function automatic res_t model(int wd, int o, bit dc,
                                  int a, int b, bit c);
      res_t r;
      int mask, msb, t, bp, cc, ad, bd, x, acc;
      mask = (1 << wd) - 1;
      msb  = wd - 1;
      r.c  = 0;
      bp   = (o == 7) ? (~b & mask) : b;
      case (o)
         0, 1: r.o = a & b;
         2: r.o = a | b;
         3: r.o = a ^ b;
         4: begin
            t = a | b;
            r.o = (int'(c) << msb) | (t >> 1);
            r.c = t[0];
         end
         5: begin
            t = a | b;
            r.o = ((t << 1) | int'(c)) & mask;
            r.c = t[msb];
         end
         default: begin
            t = a + bp + int'(c);
            r.o = t & mask;
            r.c = t[wd];
         end
      endcase
      if (o == 0) r.v = b[msb-1];
      else r.v = (((a ^ r.o) & (bp ^ r.o)) >> msb) & 1;
      r.edges = 0;
      if (dc && o >= 6) begin
         cc = c;
         acc = 0;
         for (int i = 0; i < wd / 4; i++) begin
            ad = (a >> (4 * i)) & 15;
            bd = (b >> (4 * i)) & 15;
            if (o == 6) begin
               x = ad + bd + cc;
               if (x > 9) begin x = (x + 6) & 15; cc = 1; end
               else cc = 0;
            end else begin
               x = ad - bd - (1 - cc);
               if (x < 0) begin x = (x + 10) & 15; cc = 0; end
               else cc = 1;
            end
            acc = acc | (x << (4 * i));
         end
         r.o = acc;
         r.c = cc[0];
         r.edges = wd / 4;
      end
      r.z = (r.o == 0);
      r.n = (o == 0) ? b[msb] : r.o[msb];
      return r;
   endfunction

   task automatic do_op(string nm, int o, bit dc, int a,
                        int b, bit c, res_t e);
      int off;
      @(negedge clk);
      op = 3'(o); dec = dc; ai = 8'(a); bi = 8'(b);
      ci = c; in_valid = 1; out_ready = 1;
      chk({nm, ".in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 0;
      off = 0;
      @(negedge clk);
      while (!out_valid && off < 20) begin
         chk({nm, ".busy"}, in_ready, 0);
         @(negedge clk);
         off++;
      end
      chk({nm, ".edges"}, off, e.edges);
      chk({nm, ".out"}, out, e.o);
      chk({nm, ".n"}, n_o, e.n);
      chk({nm, ".v"}, v_o, e.v);
      chk({nm, ".z"}, z_o, e.z);
      chk({nm, ".c"}, c_o, e.c);
   endtask

   task automatic settle();
      in_valid = 0;
      out_ready = 1;
      repeat (2) @(negedge clk);
   endtask

   vec_t tv[13];
   res_t e;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{6, 0, 'h50, 'h50, 0, 'hA0, 1, 1, 0, 0, 0};
      tv[1]  = '{6, 1, 'h58, 'h46, 0, 'h04, 0, 1, 0, 1, 2};
      tv[2]  = '{7, 1, 'h12, 'h21, 1, 'h91, 1, 0, 0, 0, 2};
      tv[3]  = '{7, 0, 'h12, 'h21, 1, 'hF1, 1, 0, 0, 0, 0};
      tv[4]  = '{0, 0, 'h0F, 'hC0, 0, 'h00, 1, 1, 1, 0, 0};
      tv[5]  = '{3, 0, 'hFF, 'h0F, 0, 'hF0, 1, 0, 0, 0, 0};
      tv[6]  = '{4, 0, 'h81, 'h00, 1, 'hC0, 1, 0, 0, 1, 0};
      tv[7]  = '{5, 0, 'h81, 'h00, 0, 'h02, 0, 0, 0, 1, 0};
      tv[8]  = '{1, 0, 'hF0, 'h0F, 0, 'h00, 0, 0, 1, 0, 0};
      tv[9]  = '{2, 0, 'h80, 'h01, 0, 'h81, 1, 0, 0, 0, 0};
      tv[10] = '{6, 0, 'hFF, 'h01, 0, 'h00, 0, 0, 1, 1, 0};
      tv[11] = '{6, 1, 'h99, 'h01, 0, 'h00, 0, 0, 1, 1, 2};
      tv[12] = '{7, 1, 'h00, 'h01, 1, 'h99, 1, 0, 0, 0, 2};

      #1;
      chk("rst.out", out, 0);
      chk("rst.flags", {n_o, v_o, z_o, c_o}, 0);
      chk("rst.out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst.in_ready", in_ready, 1);

      foreach (tv[i]) begin
         e = '{tv[i].eo, tv[i].en, tv[i].ev,
               tv[i].ez, tv[i].ec, tv[i].edges};
         do_op($sformatf("vec%0d", i), tv[i].op, tv[i].dec,
               tv[i].a, tv[i].b, tv[i].ci, e);
      end

      for (int i = 0; i < 150; i++) begin
         int o, a, b;
         bit dc, c;
         o  = $urandom_range(0, 7);
         dc = 1'($urandom_range(0, 1));
         c  = 1'($urandom_range(0, 1));
         a  = $urandom_range(0, 255);
         b  = $urandom_range(0, 255);
         if (o == 4 || o == 5) begin
            if ($urandom_range(0, 1) == 1) b = 0;
            else a = 0;
         end
         e = model(8, o, dc, a, b, c);
         do_op($sformatf("rnd%0d", i), o, dc, a, b, c, e);
      end

      // output held under backpressure, queued op waits
      settle();
      op = 3'd0; dec = 0; ai = 8'h0F; bi = 8'hC0; ci = 0;
      in_valid = 1; out_ready = 0;
      @(posedge clk);
      #1 op = 3'd3; ai = 8'h3C; bi = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold.out", out, 8'h00);
         chk("hold.flags", {n_o, v_o, z_o, c_o}, 4'b1110);
         chk("hold.out_valid", out_valid, 1);
         chk("hold.in_ready", in_ready, 0);
      end
      out_ready = 1;
      #1 chk("hold.release_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      chk("hold.next_out", out, 8'h33);
      chk("hold.next_valid", out_valid, 1);
      chk("hold.next_flags", {n_o, v_o, z_o, c_o}, 4'b0000);

      // flush mid-DEC and flush over a would-be accept
      settle();
      e = model(8, 6, 0, 'h50, 'h50, 0);
      do_op("pre_flush", 6, 0, 'h50, 'h50, 0, e);
      @(negedge clk);
      op = 3'd6; dec = 1; ai = 8'h58; bi = 8'h46; ci = 0;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
      repeat (3) begin
         @(negedge clk);
         chk("flush.dec_valid", out_valid, 0);
         chk("flush.dec_out", out, 8'hA0);
      end
      chk("flush.dec_ready", in_ready, 1);
      op = 3'd3; dec = 0; ai = 8'h00; bi = 8'h01;
      in_valid = 1; flush = 1;
      @(posedge clk);
      #1 in_valid = 0; flush = 0;
      @(negedge clk);
      chk("flush.cap_valid", out_valid, 0);
      chk("flush.cap_out", out, 8'hA0);

      // W=16 decimal carry ripple through every digit
      settle();
      w_op = 3'd6; w_dec = 1; w_a = 16'h9999;
      w_b = 16'h0001; w_ci = 0; w_valid = 1;
      @(posedge clk);
      #1 w_valid = 0;
      begin
         int off;
         off = 0;
         @(negedge clk);
         while (!w_ovalid && off < 20) begin
            chk("w16.busy", w_ready, 0);
            @(negedge clk);
            off++;
         end
         chk("w16.edges", off, 4);
      end
      chk("w16.out", w_out, 16'h0000);
      chk("w16.c", w_c, 1);
      chk("w16.z", w_z, 1);
      chk("w16.n", w_n, 0);

      // reset while a decimal op is in flight
      settle();
      op = 3'd6; dec = 1; ai = 8'h58; bi = 8'h46; ci = 0;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("rstdec.out", out, 0);
      chk("rstdec.flags", {n_o, v_o, z_o, c_o}, 0);
      chk("rstdec.out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         chk("rstdec.no_result", out_valid, 0);
      end
      e = '{'hF0, 1, 0, 0, 0, 0};
      do_op("post_rst_xor", 3, 0, 'hFF, 'h0F, 0, e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
